// File: rtl/comp_arbiter_if.sv
// Request/response bundle between the requesters and the shared-comparator arbiter.
// The requester side drives operands and rsp_ready; the arbiter drives grants and results.
interface comp_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic                          rsp_gt;
  logic                          rsp_eq;
  logic                          rsp_lt;
  logic                          busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy
  );
endinterface

// File: rtl/comp_arbiter.sv
// Round-robin sequencer sharing one signed comparator among NUM_REQ requesters.
// One compare per IDLE->COMPARE->RESPOND pass; results are tagged with the requester index.
module comp_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  comp_arbiter_if.slave bus
);
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COMPARE = 2'd1, RESPOND = 2'd2} state_t;

  state_t                        r_state;
  logic [ID_WIDTH-1:0]           r_last;
  logic [ID_WIDTH-1:0]           r_id;
  logic [ID_WIDTH-1:0]           r_rsp_id;
  logic signed [DATA_WIDTH-1:0]  r_a;
  logic signed [DATA_WIDTH-1:0]  r_b;
  logic                          r_rsp_valid;
  logic                          r_gt;
  logic                          r_eq;
  logic                          r_lt;

  logic [NUM_REQ-1:0]            w_gnt;
  logic [ID_WIDTH-1:0]           w_gnt_id;
  logic                          w_found;
  int                            w_idx;

  // Rotating priority search starting one past the last winner.
  always_comb begin
    w_gnt    = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_WIDTH'(w_idx);
      end
    end
    if (r_state == IDLE && w_found)
      w_gnt[w_gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= ID_WIDTH'(NUM_REQ - 1);
      r_id        <= '0;
      r_rsp_id    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= bus.req_a[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
            r_b     <= bus.req_b[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
            r_id    <= w_gnt_id;
            r_last  <= w_gnt_id;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          r_gt        <= (r_a >  r_b);
          r_eq        <= (r_a == r_b);
          r_lt        <= (r_a <  r_b);
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESPOND;
        end
        RESPOND: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grants are combinational, so reset must mask them directly.
  assign bus.req_ready = rst_n ? w_gnt : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_gt    = r_gt;
  assign bus.rsp_eq    = r_eq;
  assign bus.rsp_lt    = r_lt;
  assign bus.busy      = (r_state != IDLE);
endmodule
